// File: rtl/checkbits_seq_monitor.sv
// Ordered checkbits sequence monitor: glitch-filtered matching against a programmable
// expected-value table, with per-step latency, per-step timeout and optional strict ordering.
module checkbits_seq_monitor #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int STABLE = 2,
  parameter int CNT_W  = 24
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [WIDTH-1:0]         checkbits,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]         cfg_data,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  input  logic [CNT_W-1:0]         timeout_lim,
  input  logic                     strict,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   step_idx,
  output logic                     lat_valid,
  output logic [CNT_W-1:0]         lat_cycles
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;
  localparam int FW = $clog2(STABLE + 1);
  localparam logic [FW-1:0]    FILT_SAT = FW'(STABLE);
  localparam logic [FW-1:0]    FILT_ONE = FW'(1);
  localparam logic [FW-1:0]    FILT_ZERO = FW'(0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]    IDX_ZERO = {IW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tbl_q [DEPTH];
  logic [WIDTH-1:0] prev_q;
  logic [FW-1:0]    filt_q, filt_d, filt_nxt_s;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d, step_inc_s;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [IW-1:0]    len_q, len_d, idx_q, idx_d;
  logic             strict_q, strict_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             fail_q, fail_d, timeout_q, timeout_d;
  logic             lat_valid_q, lat_valid_d;
  logic [CNT_W-1:0] lat_cycles_q, lat_cycles_d;
  logic [WIDTH-1:0] exp_s;
  logic             chg_s, stable_s, ahead_s, run_s, match_s;
  logic             order_err_s, timeout_s, last_s, start_ok_s;

  // Table writes are blocked during a run; reset deliberately leaves the contents intact.
  always_ff @(posedge wb_clk_i) begin
    if (cfg_we && (state_q != S_RUN)) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  // A value becomes stable once, on the cycle its run length first reaches STABLE.
  always_comb begin
    chg_s = (checkbits != prev_q);
    if (chg_s) begin
      filt_nxt_s = FILT_ONE;
    end else if (filt_q == FILT_SAT) begin
      filt_nxt_s = FILT_SAT;
    end else begin
      filt_nxt_s = filt_q + FILT_ONE;
    end
    stable_s = (filt_nxt_s == FILT_SAT) && (chg_s || (filt_q != FILT_SAT));
  end

  // Match, out-of-order and timeout detection against the latched run configuration.
  always_comb begin
    exp_s   = tbl_q[idx_q[AW-1:0]];
    ahead_s = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if ((IW'(j) > idx_q) && (IW'(j) < len_q) && (tbl_q[j] == checkbits)) begin
        ahead_s = 1'b1;
      end else begin
        ahead_s = ahead_s;
      end
    end
    run_s       = (state_q == S_RUN);
    match_s     = run_s && stable_s && (checkbits == exp_s);
    order_err_s = run_s && stable_s && strict_q && ahead_s && !match_s;
    timeout_s   = run_s && (lim_q != CNT_ZERO) && (step_cnt_q == lim_q - CNT_ONE);
    last_s      = (idx_q == len_q - IDX_ONE);
    start_ok_s  = start && !run_s;
    step_inc_s  = (step_cnt_q == CNT_MAX) ? CNT_MAX : step_cnt_q + CNT_ONE;
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a match outranks any failure in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          state_d = (cfg_len == IDX_ZERO) ? S_PASS : S_RUN;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (match_s) begin
          state_d = last_s ? S_PASS : S_RUN;
        end else if (order_err_s || timeout_s) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    len_d        = len_q;
    lim_d        = lim_q;
    strict_d     = strict_q;
    idx_d        = idx_q;
    filt_d       = filt_nxt_s;
    step_cnt_d   = step_cnt_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
    lat_valid_d  = 1'b0;
    lat_cycles_d = lat_cycles_q;
    if (start_ok_s) begin
      len_d      = cfg_len;
      lim_d      = timeout_lim;
      strict_d   = strict;
      idx_d      = IDX_ZERO;
      filt_d     = FILT_ZERO;
      step_cnt_d = CNT_ZERO;
      done_d     = (cfg_len == IDX_ZERO);
      pass_d     = (cfg_len == IDX_ZERO);
      fail_d     = 1'b0;
      timeout_d  = 1'b0;
    end else if (run_s) begin
      step_cnt_d = step_inc_s;
      if (match_s) begin
        lat_valid_d  = 1'b1;
        lat_cycles_d = step_inc_s;
        step_cnt_d   = CNT_ZERO;
        idx_d        = idx_q + IDX_ONE;
        done_d       = last_s;
        pass_d       = last_s;
      end else if (order_err_s) begin
        done_d = 1'b1;
        fail_d = 1'b1;
      end else if (timeout_s) begin
        done_d    = 1'b1;
        fail_d    = 1'b1;
        timeout_d = 1'b1;
      end else begin
        done_d = done_q;
      end
    end else begin
      lat_valid_d = 1'b0;
    end
    busy_d = (state_d == S_RUN);
  end

  // Datapath and output registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      prev_q       <= {WIDTH{1'b0}};
      filt_q       <= FILT_ZERO;
      step_cnt_q   <= CNT_ZERO;
      lim_q        <= CNT_ZERO;
      len_q        <= IDX_ZERO;
      idx_q        <= IDX_ZERO;
      strict_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      lat_valid_q  <= 1'b0;
      lat_cycles_q <= CNT_ZERO;
    end else begin
      prev_q       <= checkbits;
      filt_q       <= filt_d;
      step_cnt_q   <= step_cnt_d;
      lim_q        <= lim_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      strict_q     <= strict_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      lat_valid_q  <= lat_valid_d;
      lat_cycles_q <= lat_cycles_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign step_idx   = idx_q;
  assign lat_valid  = lat_valid_q;
  assign lat_cycles = lat_cycles_q;

endmodule
